// File: rtl/spi_burst_pkg.sv
`default_nettype none
//============================================================================
// Module   : spi_burst_pkg
// Brief    : Command encodings and FSM states for the SPI burst RAM slave.
// Revision : 1.0 - initial release
//============================================================================
package spi_burst_pkg;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        WR_ADDR = 3'd2,
        WR_DATA = 3'd3,
        RD_ADDR = 3'd4,
        RD_WAIT = 3'd5,
        RD_DATA = 3'd6
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spi_burst_ram.sv
`default_nettype none
//============================================================================
// Module   : spi_burst_ram
// Brief    : Single-port synchronous RAM, registered read-first output.
// Revision : 1.0 - initial release
//============================================================================
module spi_burst_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= din;
        end
        dout <= r_mem[addr];
    end

endmodule
`default_nettype wire

// File: rtl/spi_burst_ram_slave.sv
`default_nettype none
//============================================================================
// Module   : spi_burst_ram_slave
// Brief    : SPI slave bridge with burst read/write access to an internal RAM.
// Revision : 1.0 - initial release
//============================================================================
module spi_burst_ram_slave
    import spi_burst_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 8,
    parameter bit AUTO_INC = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic MOSI,
    input  logic SS_n,
    output logic MISO,
    output logic frame_err
);

    localparam int SH_W  = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam int CNT_W = $clog2(SH_W) + 1;
    localparam logic [CNT_W-1:0] c_data_last = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] c_addr_last = CNT_W'(ADDR_W - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [SH_W-2:0]   r_shift;
    logic [SH_W-1:0]   w_shift_next;
    logic [DATA_W-1:0] r_tx;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic              r_cmd_hi;
    logic              r_addr_done;
    logic              r_first;
    logic              w_we;
    logic [ADDR_W-1:0] w_ram_addr;
    logic [DATA_W-1:0] w_ram_dout;
    logic              w_addr_last;
    logic              w_data_last;
    logic              w_abort_err;

    assign w_shift_next = {r_shift, MOSI};
    assign w_addr_last  = (r_cnt == c_addr_last) && !r_addr_done;
    assign w_data_last  = (r_cnt == c_data_last);

    // Only a word already half-shifted (or a half-received command) counts as an error.
    assign w_abort_err = (r_state == CMD) ||
                         (((r_state == WR_ADDR) || (r_state == RD_ADDR)) && !r_addr_done && (r_cnt != '0)) ||
                         ((r_state == WR_DATA) && (r_cnt != '0));

    assign w_we = !rst && !SS_n && (r_state == WR_DATA) && w_data_last;

    // While streaming, address the following word so it is ready at the word boundary.
    always_comb begin
        w_ram_addr = r_rd_ptr;
        if (r_state == WR_DATA) begin
            w_ram_addr = r_wr_ptr;
        end else if ((r_state == RD_DATA) && AUTO_INC) begin
            w_ram_addr = r_rd_ptr + 1'b1;
        end
    end

    assign MISO = (r_state == RD_DATA) ? r_tx[DATA_W-1] : 1'b0;

    spi_burst_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk  (clk),
        .we   (w_we),
        .addr (w_ram_addr),
        .din  (w_shift_next[DATA_W-1:0]),
        .dout (w_ram_dout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (SS_n) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE: w_next_state = CMD;
                CMD: begin
                    case ({r_cmd_hi, MOSI})
                        CMD_WR_ADDR: w_next_state = WR_ADDR;
                        CMD_WR_DATA: w_next_state = WR_DATA;
                        CMD_RD_ADDR: w_next_state = RD_ADDR;
                        default:     w_next_state = RD_WAIT;
                    endcase
                end
                RD_WAIT: w_next_state = RD_DATA;
                default: w_next_state = r_state;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_shift     <= '0;
            r_tx        <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_cmd_hi    <= 1'b0;
            r_addr_done <= 1'b0;
            r_first     <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            frame_err <= SS_n && w_abort_err;
            if (SS_n) begin
                r_cnt       <= '0;
                r_shift     <= '0;
                r_tx        <= '0;
                r_addr_done <= 1'b0;
                r_first     <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_cmd_hi    <= MOSI;
                        r_cnt       <= '0;
                        r_addr_done <= 1'b0;
                    end
                    CMD: begin
                        r_cnt   <= '0;
                        r_shift <= '0;
                        r_tx    <= '0;
                    end
                    WR_ADDR, RD_ADDR: begin
                        if (!r_addr_done) begin
                            if (w_addr_last) begin
                                if (r_state == WR_ADDR) begin
                                    r_wr_ptr <= w_shift_next[ADDR_W-1:0];
                                end else begin
                                    r_rd_ptr <= w_shift_next[ADDR_W-1:0];
                                end
                                r_addr_done <= 1'b1;
                                r_cnt       <= '0;
                            end else begin
                                r_shift <= w_shift_next[SH_W-2:0];
                                r_cnt   <= r_cnt + 1'b1;
                            end
                        end
                    end
                    WR_DATA: begin
                        r_shift <= w_shift_next[SH_W-2:0];
                        if (w_data_last) begin
                            r_cnt <= '0;
                            if (AUTO_INC) begin
                                r_wr_ptr <= r_wr_ptr + 1'b1;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    RD_WAIT: begin
                        r_first <= 1'b1;
                        r_cnt   <= '0;
                    end
                    RD_DATA: begin
                        if (r_first) begin
                            r_tx    <= w_ram_dout;
                            r_cnt   <= '0;
                            r_first <= 1'b0;
                        end else if (w_data_last) begin
                            r_tx  <= w_ram_dout;
                            r_cnt <= '0;
                            if (AUTO_INC) begin
                                r_rd_ptr <= r_rd_ptr + 1'b1;
                            end
                        end else begin
                            r_tx  <= {r_tx[DATA_W-2:0], 1'b0};
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spi_burst_ram_slave.sv
`default_nettype none
//============================================================================
// Module   : tb_spi_burst_ram_slave
// Brief    : Randomised self-checking bench; instance 0 uses defaults,
//            instance 1 uses DATA_W=16, ADDR_W=4, AUTO_INC=0.
// Revision : 1.0 - initial release
//============================================================================
module tb_spi_burst_ram_slave;

    localparam logic [1:0] c_wr_addr = 2'b00;
    localparam logic [1:0] c_wr_data = 2'b01;
    localparam logic [1:0] c_rd_addr = 2'b10;
    localparam logic [1:0] c_rd_data = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] ss_n;
    logic [1:0] mosi;
    logic [1:0] miso;
    logic [1:0] ferr;

    int checks = 0;
    int errors = 0;

    // Reference memory image and pointers per instance
    logic [15:0] mem_m [2][256];
    int          wp_m  [2];
    int          rp_m  [2];

    always #5 clk = ~clk;

    spi_burst_ram_slave #(.DATA_W(8), .ADDR_W(8), .AUTO_INC(1'b1)) u_dut_a (
        .clk(clk), .rst(rst), .MOSI(mosi[0]), .SS_n(ss_n[0]),
        .MISO(miso[0]), .frame_err(ferr[0])
    );

    spi_burst_ram_slave #(.DATA_W(16), .ADDR_W(4), .AUTO_INC(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .MOSI(mosi[1]), .SS_n(ss_n[1]),
        .MISO(miso[1]), .frame_err(ferr[1])
    );

    function automatic int dw_of(input int inst);
        return (inst == 0) ? 8 : 16;
    endfunction

    function automatic int aw_of(input int inst);
        return (inst == 0) ? 8 : 4;
    endfunction

    function automatic int depth_of(input int inst);
        return 1 << aw_of(inst);
    endfunction

    function automatic bit inc_of(input int inst);
        return inst == 0;
    endfunction

    task automatic model_write(input int inst, input logic [63:0] data, input int n);
        int d;
        d = dw_of(inst);
        for (int i = 0; i < n; i++) begin
            mem_m[inst][wp_m[inst]] = 16'((data >> ((n - 1 - i) * d)) & ((64'd1 << d) - 1));
            if (inc_of(inst)) wp_m[inst] = (wp_m[inst] + 1) % depth_of(inst);
        end
    endtask

    task automatic model_read(input int inst, input int n, output logic [63:0] exp);
        int d;
        int a;
        d   = dw_of(inst);
        exp = '0;
        for (int i = 0; i < n; i++) begin
            a   = inc_of(inst) ? (rp_m[inst] + i) % depth_of(inst) : rp_m[inst];
            exp = (exp << d) | {48'd0, mem_m[inst][a]};
        end
        if (inc_of(inst)) rp_m[inst] = (rp_m[inst] + n) % depth_of(inst);
    endtask

    // Sends command plus nbits of payload, then closes the frame and samples frame_err.
    task automatic send_frame(input int inst, input logic [1:0] cmd, input logic [63:0] data,
                              input int nbits, output logic err_now, output logic err_after);
        @(negedge clk); ss_n[inst] = 1'b0; mosi[inst] = cmd[1];
        @(negedge clk); mosi[inst] = cmd[0];
        for (int i = nbits - 1; i >= 0; i--) begin
            @(negedge clk); mosi[inst] = data[i];
        end
        @(negedge clk); ss_n[inst] = 1'b1; mosi[inst] = 1'($urandom());
        @(negedge clk); err_now = ferr[inst];
        @(negedge clk); err_after = ferr[inst];
    endtask

    // Read-data frame of n words; the master holds SS_n through the edge consuming the last LSB.
    task automatic read_frame(input int inst, input int n, output logic [63:0] got,
                              output logic err_now, output logic miso_after);
        int d;
        d = dw_of(inst);
        @(negedge clk); ss_n[inst] = 1'b0; mosi[inst] = c_rd_data[1];
        @(negedge clk); mosi[inst] = c_rd_data[0];
        @(negedge clk); mosi[inst] = 1'($urandom());
        @(negedge clk); mosi[inst] = 1'($urandom());
        got = '0;
        for (int i = 0; i < n * d; i++) begin
            @(negedge clk);
            got = {got[62:0], miso[inst]};
            mosi[inst] = 1'($urandom());
        end
        @(negedge clk); ss_n[inst] = 1'b1;
        @(negedge clk); err_now = ferr[inst]; miso_after = miso[inst];
        @(negedge clk);
    endtask

    task automatic wr_burst(input int inst, input int addr, input logic [63:0] data,
                            input int n, output logic errs);
        logic e1, e2, e3, e4;
        send_frame(inst, c_wr_addr, 64'(addr), aw_of(inst), e1, e2);
        wp_m[inst] = addr;
        send_frame(inst, c_wr_data, data, n * dw_of(inst), e3, e4);
        model_write(inst, data, n);
        errs = e1 | e2 | e3 | e4;
    endtask

    task automatic rd_burst(input int inst, input int addr, input int n,
                            output logic [63:0] got, output logic [63:0] exp, output logic errs);
        logic e1, e2, e3, m;
        send_frame(inst, c_rd_addr, 64'(addr), aw_of(inst), e1, e2);
        rp_m[inst] = addr;
        read_frame(inst, n, got, e3, m);
        model_read(inst, n, exp);
        errs = e1 | e2 | e3 | m;
    endtask

    task automatic test_reset;
        rst = 1'b1; ss_n = 2'b11; mosi = 2'b00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            wp_m[i] = 0; rp_m[i] = 0;
        end
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (miso[i] !== 1'b0) begin
                errors++; $display("FAIL reset_miso[%0d]: got %b expected 0", i, miso[i]);
            end
            checks++;
            if (ferr[i] !== 1'b0) begin
                errors++; $display("FAIL reset_frame_err[%0d]: got %b expected 0", i, ferr[i]);
            end
        end
    endtask

    task automatic test_single;
        logic [63:0] got, exp;
        logic e, r;
        wr_burst(0, 'h10, 64'hA5, 1, e);
        rd_burst(0, 'h10, 1, got, exp, r);
        checks++;
        if (got[7:0] !== exp[7:0]) begin
            errors++; $display("FAIL single_read: got %h expected %h", got[7:0], exp[7:0]);
        end
        checks++;
        if ((e | r) !== 1'b0) begin
            errors++; $display("FAIL single_spurious_err: got %b expected 0", e | r);
        end
    endtask

    task automatic test_burst;
        logic [63:0] got, exp;
        logic e, r, m, e2;
        wr_burst(0, 'h20, 64'h112233, 3, e);
        rd_burst(0, 'h20, 3, got, exp, r);
        checks++;
        if (got[23:0] !== exp[23:0]) begin
            errors++; $display("FAIL burst_read: got %h expected %h", got[23:0], exp[23:0]);
        end
        // Continue at the pointers left by the bursts
        send_frame(0, c_wr_data, 64'h44, 8, e, e2);
        model_write(0, 64'h44, 1);
        read_frame(0, 1, got, r, m);
        model_read(0, 1, exp);
        checks++;
        if (got[7:0] !== exp[7:0]) begin
            errors++; $display("FAIL burst_ptr_continue: got %h expected %h", got[7:0], exp[7:0]);
        end
        checks++;
        if (m !== 1'b0) begin
            errors++; $display("FAIL miso_after_frame: got %b expected 0", m);
        end
    endtask

    task automatic test_wrap;
        logic [63:0] got, exp;
        logic e, r;
        wr_burst(0, 'hFF, 64'h5AC3, 2, e);
        rd_burst(0, 'hFF, 2, got, exp, r);
        checks++;
        if (got[15:0] !== exp[15:0]) begin
            errors++; $display("FAIL wrap_read: got %h expected %h", got[15:0], exp[15:0]);
        end
    endtask

    task automatic test_abort;
        logic [63:0] got, exp;
        logic e, r, en, ea, m;
        int nb;
        wr_burst(0, 'h40, 64'h7766, 2, e);
        for (int k = 0; k < 3; k++) begin
            nb = (k == 0) ? 5 : ((k == 1) ? 7 : int'($urandom_range(1, 7)));
            send_frame(0, c_wr_data, 64'($urandom()), nb, en, ea);
            checks++;
            if (en !== 1'b1 || ea !== 1'b0) begin
                errors++; $display("FAIL abort_pulse bits=%0d: got %b%b expected 10", nb, en, ea);
            end
        end
        rd_burst(0, 'h40, 2, got, exp, r);
        checks++;
        if (got[15:0] !== exp[15:0]) begin
            errors++; $display("FAIL abort_ram_unchanged: got %h expected %h", got[15:0], exp[15:0]);
        end
        send_frame(0, c_wr_data, 64'h99, 8, en, ea);
        model_write(0, 64'h99, 1);
        // Aborted address load must leave rd_ptr alone
        send_frame(0, c_rd_addr, 64'h0, 3, en, ea);
        checks++;
        if (en !== 1'b1 || ea !== 1'b0) begin
            errors++; $display("FAIL abort_rd_addr_pulse: got %b%b expected 10", en, ea);
        end
        rp_m[0] = 'h42;
        send_frame(0, c_rd_addr, 64'h42, 8, en, ea);
        read_frame(0, 1, got, r, m);
        model_read(0, 1, exp);
        checks++;
        if (got[7:0] !== exp[7:0]) begin
            errors++; $display("FAIL abort_wr_ptr_unchanged: got %h expected %h", got[7:0], exp[7:0]);
        end
    endtask

    task automatic test_auto_inc_off;
        logic [63:0] got, exp;
        logic e, r;
        wr_burst(1, 'h4, 64'h0F0F, 1, e);
        wr_burst(1, 'h3, 64'h1234BEEF, 2, e);
        rd_burst(1, 'h3, 2, got, exp, r);
        checks++;
        if (got[31:0] !== exp[31:0]) begin
            errors++; $display("FAIL noinc_read3: got %h expected %h", got[31:0], exp[31:0]);
        end
        rd_burst(1, 'h4, 1, got, exp, r);
        checks++;
        if (got[15:0] !== exp[15:0]) begin
            errors++; $display("FAIL noinc_read4: got %h expected %h", got[15:0], exp[15:0]);
        end
    endtask

    task automatic test_random;
        logic [63:0] got, exp, data;
        logic e, r;
        int addr, n;
        for (int it = 0; it < 8; it++) begin
            addr = int'($urandom_range(0, 255));
            n    = int'($urandom_range(1, 4));
            data = {$urandom(), $urandom()};
            data = data & ((64'd1 << (n * 8)) - 1);
            wr_burst(0, addr, data, n, e);
            rd_burst(0, addr, n, got, exp, r);
            checks++;
            if (got !== exp || (e | r) !== 1'b0) begin
                errors++;
                $display("FAIL random_burst a=%h n=%0d: got %h err %b expected %h err 0",
                         addr, n, got, e | r, exp);
            end
        end
    endtask

    task automatic test_reset_mid_read;
        logic [63:0] got, exp;
        logic e, r, m, en, ea;
        wr_burst(0, 'h20, 64'hFF, 1, e);
        send_frame(0, c_rd_addr, 64'h20, 8, en, ea);
        @(negedge clk); ss_n[0] = 1'b0; mosi[0] = 1'b1;
        @(negedge clk); mosi[0] = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (miso[0] !== 1'b1) begin
            errors++; $display("FAIL pre_reset_miso: got %b expected 1", miso[0]);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (miso[0] !== 1'b0 || ferr !== 2'b00) begin
            errors++; $display("FAIL reset_mid_read: got miso %b ferr %b expected 0 00", miso[0], ferr);
        end
        rst = 1'b0; ss_n[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            wp_m[i] = 0; rp_m[i] = 0;
        end
        @(negedge clk);
        checks++;
        if (ferr !== 2'b00) begin
            errors++; $display("FAIL reset_silent: got ferr %b expected 00", ferr);
        end
        send_frame(0, c_wr_data, 64'h3C, 8, en, ea);
        model_write(0, 64'h3C, 1);
        read_frame(0, 1, got, r, m);
        model_read(0, 1, exp);
        checks++;
        if (got[7:0] !== exp[7:0]) begin
            errors++; $display("FAIL reset_ptrs_zero: got %h expected %h", got[7:0], exp[7:0]);
        end
        rd_burst(0, 'hFF, 2, got, exp, r);
        checks++;
        if (got[15:0] !== exp[15:0]) begin
            errors++; $display("FAIL reset_ram_kept_a: got %h expected %h", got[15:0], exp[15:0]);
        end
        rd_burst(1, 'h3, 1, got, exp, r);
        checks++;
        if (got[15:0] !== exp[15:0]) begin
            errors++; $display("FAIL reset_ram_kept_b: got %h expected %h", got[15:0], exp[15:0]);
        end
    endtask

    initial begin
        rst  = 1'b1;
        ss_n = 2'b11;
        mosi = 2'b00;
        test_reset();
        test_single();
        test_burst();
        test_wrap();
        test_abort();
        test_auto_inc_off();
        test_random();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
